mux_nway_stream: RTL and testbench
==================================

// Module: mux_nway_stream
// PURPOSE
//  Parametrised N-way, WIDTH-bit multiplexer with valid/ready handshake per channel
//  and a one-entry registered output stage.
//  Two modes: fixed select (driven by s) or round-robin arbitration across requesting channels.
//  Sits between datapath producers and one shared consumer, e.g. an ALU operand bus or a
//  memory write port. Generalises the 8-way 16-bit combinational mux.
// PARAMETERS
//  WIDTH   16            data width per channel
//  N       8             channel count, 2..32
//  SEL_W   $clog2(N)     select/index width (derived; do not override)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  IN         in   N*WIDTH   channel data; channel i = IN[i*WIDTH +: WIDTH]
//  IN_VALID   in   N         channel i has data
//  IN_READY   out  N         channel i beat accepted this cycle
//  s          in   SEL_W     channel select (MODE=0)
//  MODE       in   1         0 = fixed select, 1 = round-robin
//  OUT        out  WIDTH     registered output data
//  OUT_VALID  out  1         OUT holds a beat
//  OUT_READY  in   1         consumer accepts OUT this cycle
//  OUT_SRC    out  SEL_W     index of the channel that supplied OUT
// BEHAVIOUR
//  - Reset (async, rst_n=0): OUT=0, OUT_VALID=0, OUT_SRC=0, rr_ptr=N-1. Any in-flight beat is
//    dropped. IN_READY=0 while in reset.
//  - load_en = !OUT_VALID | OUT_READY. This allows full throughput of 1 beat/cycle with a
//    back-to-back ready.
//  - Grant is combinational each cycle:
//    - MODE=0: grant = s if s<N and IN_VALID[s]; otherwise no grant. s>=N never grants.
//    - MODE=1: grant = first i with IN_VALID[i], searching from rr_ptr+1 upward mod N.
//      rr_ptr <= grant only on a transfer.
//  - IN_READY[i] = load_en & granted & (grant==i). At most one bit is high (one-hot or zero).
//  - Transfer on IN_VALID[g] & IN_READY[g]: next edge OUT<=IN[g], OUT_SRC<=g, OUT_VALID<=1.
//    Latency: 1 cycle.
//  - load_en with no grant: OUT_VALID<=0. OUT and OUT_SRC hold their last values.
//  - Stall (OUT_VALID & !OUT_READY): OUT, OUT_SRC and OUT_VALID stay stable; all IN_READY=0.
//  - Changes to MODE or s affect only the next grant decision; a registered beat is never altered.
//  - rr_ptr is unaffected by a MODE=0 transfer. Switching to MODE=1 resumes from the stored rr_ptr.
//  - Producers may drop IN_VALID without a handshake. A beat is lost only if it was never
//    accepted (no buffering on the input side).
// CONFIGURATION
//  MUX_PKT_LOCK_EN defined:
//    - Adds IN_LAST (in, N) and OUT_LAST (out, 1); OUT_LAST is registered with OUT and
//      reset to 0.
//    - After a transfer with IN_LAST[g]=0, grant is locked to g regardless of MODE or s.
//      Other channels are not granted until g transfers a beat with IN_LAST=1. The lock
//      clears on that edge.
//    - A locked channel deasserting IN_VALID yields no grant; the lock is kept.
//    - Reset clears the lock.
//  MUX_PKT_LOCK_EN undefined:
//    - No LAST ports.
//    - Every beat is arbitrated independently as above.
// TESTING
//  1 Reset: rst_n=0 mid-stream with OUT_VALID=1 -> same cycle OUT_VALID=0, OUT=0, IN_READY=0.
//    After release, first MODE=1 grant goes to ch0.
//  2 Fixed select: WIDTH=16, N=8, MODE=0, OUT_READY=1, ch i data=i*3, all valid, s steps 0..7
//    each cycle -> OUT = 0,3,6..21 and OUT_SRC = 0..7, each one cycle after its s.
//  3 Round-robin: MODE=1, all 8 valid, OUT_READY=1 -> OUT_SRC 0,1,..7,0 one per cycle.
//    With only ch2 and ch5 valid -> 2,5,2,5.
//  4 Backpressure: OUT_VALID=1, OUT=0x0011, OUT_READY=0 for 4 cycles -> OUT stable, IN_READY=0.
//    Releasing OUT_READY accepts the next beat in the same cycle.
//  5 Invalid select: N=6, MODE=0, s=7 with all valid -> IN_READY=0 and OUT_VALID falls to 0
//    after the pending beat drains.
//  6 (MUX_PKT_LOCK_EN) ch1 sends a 3-beat packet interleaved with ch4 valid, MODE=1 ->
//    OUT_SRC = 1,1,1 (OUT_LAST on the 3rd), then 4.

Source files
------------

// File: rtl/mux_nway_stream.sv
// N-way WIDTH-bit stream mux with a one-entry registered output stage. Grant is fixed-select or round-robin.
// Latency 1 cycle; IN_READY is withheld while the output holds an unaccepted beat. Optional macro: MUX_PKT_LOCK_EN.
module mux_nway_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] IN,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    input  logic [SEL_W-1:0]   s,
    input  logic               MODE,
    output logic [WIDTH-1:0]   OUT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [SEL_W-1:0]   OUT_SRC
`ifdef MUX_PKT_LOCK_EN
    ,
    input  logic [N-1:0]       IN_LAST,
    output logic               OUT_LAST
`endif
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             load_en;
    logic             granted;
    logic [SEL_W-1:0] grant;
    logic             xfer;
`ifdef MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             out_last_q, out_last_d;
`endif

    always_comb begin
        load_en = !out_vld_q || OUT_READY;
        granted = 1'b0;
        grant   = '0;
        if (MODE) begin
            for (int k = 1; k <= N; k++) begin
                if (!granted && IN_VALID[(int'(rr_ptr_q) + k) % N]) begin
                    granted = 1'b1;
                    grant   = SEL_W'((int'(rr_ptr_q) + k) % N);
                end
            end
        end else if (int'(s) < N) begin
            granted = IN_VALID[s];
            grant   = s;
        end
`ifdef MUX_PKT_LOCK_EN
        // A packet in progress owns the output regardless of MODE/s.
        if (lock_q) begin
            granted = IN_VALID[lock_ch_q];
            grant   = lock_ch_q;
        end
`endif
        xfer     = rst_n && load_en && granted;
        IN_READY = '0;
        if (xfer) IN_READY[grant] = 1'b1;

        out_d     = out_q;
        out_vld_d = out_vld_q;
        out_src_d = out_src_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d     = lock_q;
        lock_ch_d  = lock_ch_q;
        out_last_d = out_last_q;
`endif
        if (load_en) begin
            if (granted) begin
                out_d     = IN[int'(grant)*WIDTH +: WIDTH];
                out_vld_d = 1'b1;
                out_src_d = grant;
`ifdef MUX_PKT_LOCK_EN
                out_last_d = IN_LAST[grant];
                lock_d     = !IN_LAST[grant];
                lock_ch_d  = grant;
`endif
            end else begin
                out_vld_d = 1'b0;
            end
        end
        if (xfer && MODE) rr_ptr_d = grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_src_q  <= '0;
            rr_ptr_q   <= SEL_W'(N - 1);
`ifdef MUX_PKT_LOCK_EN
            lock_q     <= 1'b0;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
`endif
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
`endif
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_vld_q;
    assign OUT_SRC   = out_src_q;
`ifdef MUX_PKT_LOCK_EN
    assign OUT_LAST  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_nway_stream.sv
// Directed bench for mux_nway_stream: an 8-channel instance plus a 6-channel instance for out-of-range select.
module tb_mux_nway_stream;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  in_dat;
    logic [7:0]    in_vld;
    logic [7:0]    in_rdy;
    logic [2:0]    sel;
    logic          mode;
    logic [15:0]   out_dat;
    logic          out_vld;
    logic          out_rdy;
    logic [2:0]    out_src;

    logic [95:0]   in6_dat;
    logic [5:0]    in6_vld;
    logic [5:0]    in6_rdy;
    logic [2:0]    sel6;
    logic [15:0]   out6_dat;
    logic          out6_vld;
    logic          out6_rdy;
    logic [2:0]    out6_src;
`ifdef MUX_PKT_LOCK_EN
    logic [7:0]    in_last;
    logic          out_last;
    logic [5:0]    in6_last;
    logic          out6_last;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nway_stream #(.WIDTH(16), .N(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .IN(in_dat), .IN_VALID(in_vld), .IN_READY(in_rdy),
        .s(sel), .MODE(mode), .OUT(out_dat), .OUT_VALID(out_vld), .OUT_READY(out_rdy),
        .OUT_SRC(out_src)
`ifdef MUX_PKT_LOCK_EN
        , .IN_LAST(in_last), .OUT_LAST(out_last)
`endif
    );

    mux_nway_stream #(.WIDTH(16), .N(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .IN(in6_dat), .IN_VALID(in6_vld), .IN_READY(in6_rdy),
        .s(sel6), .MODE(1'b0), .OUT(out6_dat), .OUT_VALID(out6_vld), .OUT_READY(out6_rdy),
        .OUT_SRC(out6_src)
`ifdef MUX_PKT_LOCK_EN
        , .IN_LAST(in6_last), .OUT_LAST(out6_last)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_vld   = '0;
        sel      = '0;
        mode     = 1'b0;
        out_rdy  = 1'b1;
        in6_vld  = '0;
        sel6     = '0;
        out6_rdy = 1'b1;
`ifdef MUX_PKT_LOCK_EN
        in_last  = '1;
        in6_last = '1;
`endif
        for (int i = 0; i < 8; i++) in_dat[i*16 +: 16] = 16'(i * 3);
        for (int i = 0; i < 6; i++) in6_dat[i*16 +: 16] = 16'(16'h0a00 + i);

        // Reset values
        #2;
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out", 32'(out_dat), 0);
        check("rst_out_src", 32'(out_src), 0);
        in_vld = 8'hff;
        #1;
        check("rst_in_rdy", 32'(in_rdy), 0);
        step();
        rst_n = 1'b1;

        // Fixed select sweep, OUT one cycle after s
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            check($sformatf("fix_in_rdy%0d", i), 32'(in_rdy), 32'(1 << i));
            step();
            check($sformatf("fix_out%0d", i), 32'(out_dat), 32'(i * 3));
            check($sformatf("fix_src%0d", i), 32'(out_src), 32'(i));
            check($sformatf("fix_vld%0d", i), 32'(out_vld), 1);
        end

        // Round-robin over all eight, wrapping to 0
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rr_src%0d", i), 32'(out_src), 32'(i % 8));
            check($sformatf("rr_out%0d", i), 32'(out_dat), 32'((i % 8) * 3));
        end
        in_vld = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr25_src%0d", i), 32'(out_src), (i % 2 == 0) ? 32'd2 : 32'd5);
        end

        // Backpressure hold and same-cycle release
        mode = 1'b0;
        in_vld = 8'hff;
        in_dat[3*16 +: 16] = 16'h0011;
        sel = 3'd3;
        step();
        check("bp_load_out", 32'(out_dat), 32'h0011);
        out_rdy = 1'b0;
        sel = 3'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp_in_rdy%0d", i), 32'(in_rdy), 0);
            step();
            check($sformatf("bp_out%0d", i), 32'(out_dat), 32'h0011);
            check($sformatf("bp_src%0d", i), 32'(out_src), 3);
            check($sformatf("bp_vld%0d", i), 32'(out_vld), 1);
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_rdy), 32'h10);
        step();
        check("bp_next_out", 32'(out_dat), 12);
        check("bp_next_src", 32'(out_src), 4);

        // Mid-stream async reset, then round-robin restarts at ch0
        for (int i = 0; i < 8; i++) in_dat[i*16 +: 16] = 16'(16'h0100 + i);
        mode = 1'b1;
        check("mid_pre_vld", 32'(out_vld), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(out_vld), 0);
        check("mid_rst_out", 32'(out_dat), 0);
        check("mid_rst_rdy", 32'(in_rdy), 0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_src", 32'(out_src), 0);
        check("post_rst_out", 32'(out_dat), 32'h0100);
        step();
        check("post_rst_src2", 32'(out_src), 1);

        // Out-of-range select on a 6-channel instance
        in_vld = '0;
        in6_vld = 6'h3f;
        sel6 = 3'd2;
        step();
        check("n6_load_src", 32'(out6_src), 2);
        check("n6_load_vld", 32'(out6_vld), 1);
        sel6 = 3'd7;
        out6_rdy = 1'b0;
        #1;
        check("n6_s7_rdy_stall", 32'(in6_rdy), 0);
        step();
        check("n6_s7_hold_vld", 32'(out6_vld), 1);
        out6_rdy = 1'b1;
        #1;
        check("n6_s7_rdy", 32'(in6_rdy), 0);
        step();
        check("n6_s7_drained", 32'(out6_vld), 0);
        check("n6_s7_src_hold", 32'(out6_src), 2);
        check("n6_s7_out_hold", 32'(out6_dat), 32'h0a02);
        sel6 = 3'd6;
        #1;
        check("n6_s6_rdy", 32'(in6_rdy), 0);
        in6_vld = '0;

`ifdef MUX_PKT_LOCK_EN
        // Packet lock: ch1 three-beat packet beats ch4 until its last beat
        mode = 1'b1;
        in_vld = 8'h01;
        step();
        check("pk_prime_src", 32'(out_src), 0);
        in_vld = 8'b0001_0010;
        in_last = 8'hfd;
        step();
        check("pk_b0_src", 32'(out_src), 1);
        check("pk_b0_last", 32'(out_last), 0);
        step();
        check("pk_b1_src", 32'(out_src), 1);
        in_last = 8'hff;
        step();
        check("pk_b2_src", 32'(out_src), 1);
        check("pk_b2_last", 32'(out_last), 1);
        step();
        check("pk_next_src", 32'(out_src), 4);
        check("pk_next_last", 32'(out_last), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
